// File: rtl/hwpe_stream_split_ctrl_pkg.sv
// Shared types and configuration helpers for the HWPE stream split controller.
// Optional feature macro: HWPE_STREAM_SPLIT_CTRL_PERF_EN (stall counter).
package hwpe_stream_split_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } split_ctrl_state_e;

  // Returns the per-lane slice width, or 0 when the configuration is illegal
  // (lane count out of range or width not divisible into whole-byte slices).
  function automatic int unsigned split_lane_width(int unsigned width_in,
                                                   int unsigned nb_lanes);
    if (nb_lanes < 2 || nb_lanes > 32) return 0;
    if ((width_in % (8 * nb_lanes)) != 0) return 0;
    return width_in / nb_lanes;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE valid/ready stream bundle with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_split_lane_tracker.sv
// Per-lane acceptance tracking for the split: lanes that already took their
// slice drop valid until the whole input beat is released.
module hwpe_stream_split_lane_tracker #(
  parameter int unsigned NB_LANES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                in_valid,
  input  logic [NB_LANES-1:0] mask,
  input  logic [NB_LANES-1:0] lane_ready,
  output logic [NB_LANES-1:0] lane_valid,
  output logic                in_ready
);

  logic [NB_LANES-1:0] acc_q, acc_d;
  logic [NB_LANES-1:0] lane_ok;
  logic [NB_LANES-1:0] lane_hs;

  always_comb begin
    lane_valid = {NB_LANES{run & in_valid}} & mask & ~acc_q;
    lane_hs    = lane_valid & lane_ready;
    lane_ok    = acc_q | ~mask | lane_hs;
    in_ready   = run & (&lane_ok);
  end

  always_comb begin
    acc_d = acc_q;
    if (!run) begin
      acc_d = '0;
    end else if (in_valid && in_ready) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q | lane_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_split_ctrl.sv
// Wide-to-narrow HWPE stream split with independent per-lane handshakes and a
// beat-counted job FSM. Macro HWPE_STREAM_SPLIT_CTRL_PERF_EN adds stall_cnt_o.
module hwpe_stream_split_ctrl
  import hwpe_stream_split_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned NB_OUT_STREAMS = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [NB_OUT_STREAMS-1:0] lane_mask_i,
  input  logic [CNT_WIDTH-1:0]      nb_beats_i,
  hwpe_stream_intf_stream.sink      push_i,
  hwpe_stream_intf_stream.source    pop_o [NB_OUT_STREAMS-1:0],
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      beat_cnt_o
`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  // Zero here marks an illegal width/lane-count combination.
  localparam int unsigned LaneW = split_lane_width(DATA_WIDTH_IN, NB_OUT_STREAMS);
  localparam int unsigned StrbW = LaneW / 8;

  split_ctrl_state_e         state_q, state_d;
  logic [NB_OUT_STREAMS-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]      nb_q, nb_d;
  logic [CNT_WIDTH-1:0]      beat_cnt_q, beat_cnt_d;

  logic                      soft_rst;
  logic                      run;
  logic                      push_valid;
  logic                      push_ready;
  logic                      beat_done;
  logic [NB_OUT_STREAMS-1:0] lane_valid;
  logic [NB_OUT_STREAMS-1:0] lane_ready;

  assign soft_rst   = rst_i | clear_i;
  assign run        = (state_q == StRun);
  assign push_valid = push_i.valid;
  assign beat_done  = push_valid & push_ready;

  assign push_i.ready = push_ready;

  for (genvar g = 0; g < NB_OUT_STREAMS; g++) begin : gen_lane
    assign pop_o[g].data  = push_i.data[g*LaneW +: LaneW];
    assign pop_o[g].strb  = push_i.strb[g*StrbW +: StrbW];
    assign pop_o[g].valid = lane_valid[g];
    assign lane_ready[g]  = pop_o[g].ready;
  end

  hwpe_stream_split_lane_tracker #(
    .NB_LANES (NB_OUT_STREAMS)
  ) u_tracker (
    .clk        (clk_i),
    .rst        (soft_rst),
    .run        (run),
    .in_valid   (push_valid),
    .mask       (mask_q),
    .lane_ready (lane_ready),
    .lane_valid (lane_valid),
    .in_ready   (push_ready)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    nb_d       = nb_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // An empty mask means "all lanes" so a job can never deadlock.
          mask_d     = (lane_mask_i == '0) ? '1 : lane_mask_i;
          nb_d       = nb_beats_i;
          beat_cnt_d = '0;
          state_d    = (nb_beats_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (beat_done) begin
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          if (beat_cnt_q == nb_q - CNT_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      nb_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      nb_q       <= nb_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy_o     = run;
  assign done_o     = (state_q == StDone);
  assign beat_cnt_o = beat_cnt_q;

`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && start_i) begin
      stall_d = '0;
    end else if (run && push_valid && !push_ready && !(&stall_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_split_ctrl.sv
// Bench for hwpe_stream_split_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a job-level model.
module tb_hwpe_stream_split_ctrl;

  localparam int unsigned DW  = 128;
  localparam int unsigned NB  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned LW  = DW / NB;
  localparam int unsigned SW  = LW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] mask = '0;
  logic [CW-1:0] nb = '0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW/8-1:0] push_strb = '0;
  logic [NB-1:0] pop_ready = '0;

  logic          push_ready;
  logic [NB-1:0] pop_valid;
  logic [DW-1:0] pop_data;
  logic [DW/8-1:0] pop_strb;
  logic          busy, done;
  logic [CW-1:0] beat_cnt;
`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(LW)) pop [NB-1:0] ();

  assign push.valid = push_valid;
  assign push.data  = push_data;
  assign push.strb  = push_strb;
  assign push_ready = push.ready;

  for (genvar g = 0; g < NB; g++) begin : gen_pop
    assign pop[g].ready          = pop_ready[g];
    assign pop_valid[g]          = pop[g].valid;
    assign pop_data[g*LW +: LW]  = pop[g].data;
    assign pop_strb[g*SW +: SW]  = pop[g].strb;
  end

  hwpe_stream_split_ctrl #(
    .DATA_WIDTH_IN  (DW),
    .NB_OUT_STREAMS (NB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .start_i     (start),
    .lane_mask_i (mask),
    .nb_beats_i  (nb),
    .push_i      (push),
    .pop_o       (pop),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt)
`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: a job is active or finishing; within a beat we remember
  // which enabled lanes have already taken their slice.
  bit            m_run = 1'b0;
  bit            m_done = 1'b0;
  int            m_total = 0;
  int            m_beats = 0;
  logic [NB-1:0] m_mask = '0;
  logic [NB-1:0] m_taken = '0;
  longint        m_stall = 0;

  always @(negedge clk) begin
    logic [NB-1:0] e_valid;
    logic          e_ready;
    logic [DW-1:0] dmask;
    logic [DW/8-1:0] smask;
    e_valid = '0;
    e_ready = 1'b0;
    if (m_run) begin
      e_ready = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (m_mask[i] && !m_taken[i] && push_valid) e_valid[i] = 1'b1;
        // the beat leaves only once every enabled lane has its slice
        if (m_mask[i] && !m_taken[i] && !(push_valid && pop_ready[i])) e_ready = 1'b0;
      end
    end
    dmask = '0;
    smask = '0;
    for (int i = 0; i < NB; i++) begin
      if (e_valid[i]) begin
        dmask[i*LW +: LW] = '1;
        smask[i*SW +: SW] = '1;
      end
    end
    if (chk_en) begin
      check("pop_valid", DW'(pop_valid), DW'(e_valid));
      check("push_ready", DW'(push_ready), DW'(e_ready));
      check("busy", DW'(busy), DW'(m_run));
      check("done", DW'(done), DW'(m_done));
      check("beat_cnt", DW'(beat_cnt), DW'(m_beats));
      check("pop_data", pop_data & dmask, push_data & dmask);
      check("pop_strb", DW'(pop_strb & smask), DW'(push_strb & smask));
`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
      check("stall_cnt", DW'(stall_cnt), DW'(m_stall));
`endif
    end
    if (rst || clear) begin
      m_run <= 1'b0; m_done <= 1'b0; m_total <= 0; m_beats <= 0;
      m_mask <= '0; m_taken <= '0; m_stall <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_mask  <= (mask == '0) ? '1 : mask;
        m_total <= int'(nb);
        m_beats <= 0;
        m_taken <= '0;
        m_stall <= 0;
        if (nb == '0) m_done <= 1'b1;
        else m_run <= 1'b1;
      end
    end else begin
      if (push_valid && e_ready) begin
        m_taken <= '0;
        m_beats <= m_beats + 1;
        if (m_beats + 1 == m_total) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end else begin
        m_taken <= m_taken | (e_valid & pop_ready);
        if (push_valid && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    push_data = {$urandom, $urandom, $urandom, $urandom};
    push_strb = 16'($urandom);
  endtask

  task automatic launch(input logic [NB-1:0] m, input logic [CW-1:0] n);
    mask = m; nb = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rnd_data();
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    push_valid = 1'b1;
    pop_ready = '1;
    @(negedge clk);
    check("rst_push_ready", DW'(push_ready), DW'(0));
    check("rst_pop_valid", DW'(pop_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_beat_cnt", DW'(beat_cnt), DW'(0));
    push_valid = 1'b0;
    tick();

    // Lock-step: all lanes ready, four back-to-back beats.
    launch(8'hFF, 16'd4);
    push_valid = 1'b1; pop_ready = '1;
    for (int b = 0; b < 4; b++) begin
      rnd_data();
      @(negedge clk);
      check("lock_push_ready", DW'(push_ready), DW'(1));
      check("lock_lane_data", pop_data, push_data);
      tick();
    end
    push_valid = 1'b0;
    @(negedge clk);
    check("lock_done", DW'(done), DW'(1));
    check("lock_beat_cnt", DW'(beat_cnt), DW'(4));
    tick();

    // Staggered ready: low lanes first, high lanes two cycles later.
    launch(8'hFF, 16'd1);
    push_valid = 1'b1; rnd_data(); pop_ready = 8'h0F;
    @(negedge clk);
    check("stag_c0_valid", DW'(pop_valid), DW'(8'hFF));
    check("stag_c0_ready", DW'(push_ready), DW'(0));
    tick();
    pop_ready = 8'h00;
    @(negedge clk);
    check("stag_c1_valid", DW'(pop_valid), DW'(8'hF0));
    check("stag_c1_ready", DW'(push_ready), DW'(0));
    tick();
    pop_ready = 8'hF0;
    @(negedge clk);
    check("stag_c2_valid", DW'(pop_valid), DW'(8'hF0));
    check("stag_c2_ready", DW'(push_ready), DW'(1));
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    check("stag_done", DW'(done), DW'(1));
    tick();

    // Partial mask: disabled lanes never ready, beats still complete.
    launch(8'h05, 16'd3);
    push_valid = 1'b1; pop_ready = 8'h05;
    for (int b = 0; b < 3; b++) begin
      rnd_data();
      @(negedge clk);
      check("part_valid", DW'(pop_valid), DW'(8'h05));
      check("part_ready", DW'(push_ready), DW'(1));
      tick();
    end
    push_valid = 1'b0;
    @(negedge clk);
    check("part_done", DW'(done), DW'(1));
    check("part_beat_cnt", DW'(beat_cnt), DW'(3));
    tick();

    // Zero-length job, then an empty mask treated as all lanes.
    push_valid = 1'b1; pop_ready = '1;
    launch(8'hFF, 16'd0);
    @(negedge clk);
    check("zero_done", DW'(done), DW'(1));
    check("zero_push_ready", DW'(push_ready), DW'(0));
    check("zero_busy", DW'(busy), DW'(0));
    tick();
    launch(8'h00, 16'd1);
    @(negedge clk);
    check("zmask_valid", DW'(pop_valid), DW'(8'hFF));
    check("zmask_ready", DW'(push_ready), DW'(1));
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    check("zmask_done", DW'(done), DW'(1));
    check("zmask_beat_cnt", DW'(beat_cnt), DW'(1));
    tick();

    // Mid-job clear with lane 3 already holding its slice.
    launch(8'hFF, 16'd5);
    push_valid = 1'b1; pop_ready = '1;
    rnd_data(); tick();
    rnd_data(); tick();
    pop_ready = 8'h08;
    @(negedge clk);
    check("clr_pre_ready", DW'(push_ready), DW'(0));
    tick();
    pop_ready = 8'h00; clear = 1'b1;
    @(negedge clk);
    check("clr_lane3_dropped", DW'(pop_valid), DW'(8'hF7));
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("clr_push_ready", DW'(push_ready), DW'(0));
    check("clr_pop_valid", DW'(pop_valid), DW'(0));
    check("clr_beat_cnt", DW'(beat_cnt), DW'(0));
    check("clr_done", DW'(done), DW'(0));
    tick();
    launch(8'hFF, 16'd1);
    @(negedge clk);
    check("clr_restart_valid", DW'(pop_valid), DW'(8'hFF));
    pop_ready = '1;
    tick();
    push_valid = 1'b0;
    tick();

`ifdef HWPE_STREAM_SPLIT_CTRL_PERF_EN
    // One lane withheld for seven cycles.
    launch(8'hFF, 16'd1);
    push_valid = 1'b1; pop_ready = 8'h7F;
    repeat (7) tick();
    pop_ready = '1;
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    check("perf_stall_cnt", DW'(stall_cnt), DW'(7));
    tick();
`endif

    // Randomized traffic, including stray starts, clears and resets.
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      mask       = ($urandom_range(0, 7) == 0) ? '0 : 8'($urandom);
      nb         = 16'($urandom_range(0, 6));
      push_valid = ($urandom_range(0, 9) < 7);
      pop_ready  = 8'($urandom) | 8'($urandom);
      clear      = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      rnd_data();
      tick();
    end
    rst = 1'b0; clear = 1'b0; start = 1'b0; push_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_split_ctrl.md
# hwpe_stream_split_ctrl

Sequencing controller for a wide-to-narrow HWPE stream split. The block accepts one `DATA_WIDTH_IN` stream and fans it out as `NB_OUT_STREAMS` equal slices. Unlike a plain lock-step split, each output lane completes its handshake independently, and the input beat is released only once every enabled lane has accepted its slice. A programmed job runs for `nb_beats_i` beats over a lane-enable mask and signals completion. The block sits between a streamer source and per-lane consumers inside an HWPE datapath.

## Interface
- `DATA_WIDTH_IN`, 128: input data width; must be divisible by `8*NB_OUT_STREAMS`.
- `NB_OUT_STREAMS`, 8: number of output lanes; 2..32.
- `CNT_WIDTH`, 16: width of the beat counter and `nb_beats_i`.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `clear_i` in 1: synchronous soft clear; identical effect to `rst_i`.
- `start_i` in 1: launch job; sampled in IDLE only.
- `lane_mask_i` in NB_OUT_STREAMS: enabled lanes; latched at start.
- `nb_beats_i` in CNT_WIDTH: beats in the job; latched at start.
- `push_i` sink hwpe_stream_intf_stream: DATA_WIDTH_IN input stream.
- `pop_o` source hwpe_stream_intf_stream[NB_OUT_STREAMS]: outputs, each `DATA_WIDTH_IN/NB_OUT_STREAMS` wide.
- `busy_o` out 1: high in RUN.
- `done_o` out 1: one-cycle pulse at job end.
- `beat_cnt_o` out CNT_WIDTH: beats completed in the current or last job.

## Operation
- States are IDLE, RUN and DONE. Reset and clear force IDLE and zero `acc_q`, `beat_cnt_q`, `mask_q` and `nb_q`. Reset values of outputs: `push_i.ready`=0, all `pop_o[i].valid`=0, `busy_o`=0, `done_o`=0, `beat_cnt_o`=0.
- IDLE: `push_i.ready`=0 and all lane valids are 0.
  - On `start_i`: latch the mask; an all-zero `lane_mask_i` is latched as all-ones. Latch `nb_beats_i` and zero `beat_cnt_q`.
  - If `nb_beats_i`=0, go to DONE. Otherwise go to RUN.
- RUN:
  - `pop_o[i].data` = `push_i.data[i*W +: W]`, and the strb slice likewise. Both are driven on every lane regardless of the mask.
  - `pop_o[i].valid` = `push_i.valid & mask_q[i] & ~acc_q[i]`.
  - `lane_ok[i]` = `acc_q[i] | ~mask_q[i] | (pop_o[i].valid & pop_o[i].ready)`.
  - `push_i.ready` = AND of all `lane_ok` bits.
  - Beat complete (`push_i.valid & push_i.ready`): clear `acc_q` to 0 and increment `beat_cnt_q`. If the pre-increment count equals `nb_q-1`, go to DONE.
  - Otherwise: `acc_q` |= per-lane handshakes, so a lane that has accepted its slice drops valid until the beat completes.
  - `start_i` is ignored.
- DONE: `done_o`=1 for exactly this cycle, then go to IDLE unconditionally. `beat_cnt_o` holds its value until the next start.
- Simultaneous events:
  - Clear or reset has priority over everything.
  - `start_i` in the DONE cycle is ignored.
  - All lanes ready in the same cycle completes the beat with zero stall.
- Arithmetic: `beat_cnt_q` counts at CNT_WIDTH and never wraps within a job, since `nb_q` ≤ 2^CNT_WIDTH−1.

## Timing
- Data path is combinational: zero latency from push to pop.
- `push_i.ready` and the lane valids are combinational from the registered `acc_q`/`mask_q`/state plus the current valid and ready inputs. There is no ready→valid dependency in the pop direction.
- Throughput is 1 beat/cycle when all enabled lanes are ready.
- `done_o` asserts the cycle after the last beat's handshake.
- `busy_o` rises the cycle after `start_i` and falls in the DONE cycle.

## Configuration
- Macro: `HWPE_STREAM_SPLIT_CTRL_PERF_EN`.
- Defined: adds output `stall_cnt_o[31:0]`.
  - It counts RUN cycles where `push_i.valid & ~push_i.ready`, saturating at 2^32−1.
  - It is zeroed on start, reset and clear.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `hwpe_stream_split_ctrl_pkg` holds:
  - typedef `split_ctrl_state_e` (IDLE, RUN, DONE);
  - the width-check constant function for `DATA_WIDTH_IN/NB_OUT_STREAMS`.
- One sub-module, `hwpe_stream_split_lane_tracker`, holds the `acc_q` register, the `lane_ok` reduction and the lane valid generation.
- FSM and counters stay in the top module.

## Test plan
- **Lock-step:** all lanes always ready, mask 0xFF, nb_beats=4, 4 back-to-back beats.
  - Required: push ready every cycle.
  - Required: lane i data = input slice i.
  - Required: `done_o` pulses in the cycle after beat 4, and `beat_cnt_o`=4.
- **Staggered ready:** lanes 0–3 ready in cycle 0, lanes 4–7 ready in cycle 2.
  - Required: lanes 0–3 drop valid after cycle 0.
  - Required: `push_i.ready` rises only in cycle 2, and each lane handshakes exactly once per beat.
- **Partial mask:** mask 0x05 with lanes 1, 3–7 never ready.
  - Required: only lanes 0 and 2 assert valid.
  - Required: beats complete and `done_o` pulses after nb_beats=3.
- **Zero-length and zero-mask:** nb_beats=0, then start with mask 0x00 and nb_beats=1.
  - Required: nb_beats=0 gives an immediate DONE pulse with no push handshake.
  - Required: mask 0x00 behaves as all-ones.
- **Mid-job clear:** assert `clear_i` after 2 of 5 beats with lane 3 already accepted.
  - Required: next cycle is IDLE with `push_i.ready`=0, all valids 0, `beat_cnt_o`=0 and no `done_o`.
  - Required: a fresh start re-presents all lanes.
- **Perf (macro defined):** input valid with one lane withheld for 7 cycles.
  - Required: `stall_cnt_o`=7.
